inst_fetch_ctrl: RTL and testbench
==================================

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameters: none; all widths fixed at 32-bit addresses and 32-bit instructions.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pc_i  input  32  fetch virtual address from pc_reg (inst_vaddr_o).
REQ-005 stall  input  1  from CTRL; holds the fetch stage.
REQ-006 flush  input  1  from CTRL; exception flush.
REQ-007 pc_read_ready  output  1  to pc_reg; high in the cycle the current pc_i is accepted by the bus.
REQ-008 inst_req  output  1  bus request, SRAM-like.
REQ-009 inst_addr  output  32  bus address.
REQ-010 inst_addr_ok  input  1  bus accepted the address this cycle.
REQ-011 inst_data_ok  input  1  bus returns read data this cycle.
REQ-012 inst_rdata  input  32  bus read data, valid when inst_data_ok=1.
REQ-013 inst_o  output  32  fetched instruction to IF/ID.
REQ-014 inst_pc_o  output  32  address of inst_o.
REQ-015 inst_valid_o  output  1  inst_o/inst_pc_o valid.
REQ-016 busy_o  output  1  a request is pending or outstanding (state REQ or WAIT).

Function
REQ-017 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE; at most one bus transaction SHALL be outstanding.
REQ-018 IDLE: all outputs 0; the FSM SHALL go to REQ on the first cycle after rst deasserts, giving a one-cycle boot delay.
REQ-019 REQ: inst_req SHALL be (!stall || flush); inst_addr SHALL equal pc_i combinationally.
REQ-020 REQ: an address handshake occurs when inst_req && inst_addr_ok. On a handshake, pc_read_ready=1 in that cycle, pc_i is latched into req_pc, and the FSM goes to WAIT. Otherwise pc_read_ready=0 and the FSM stays in REQ.
REQ-021 REQ with flush=1: no cancel is needed, because pc_i already carries the flush target; the handshake proceeds normally.
REQ-022 WAIT: inst_req=0; a cancel flag SHALL be set when flush=1 and inst_data_ok=0.
REQ-023 WAIT with inst_data_ok=1 and (cancel or flush): the data SHALL be dropped, cancel cleared, and the FSM goes to REQ; inst_valid_o stays 0.
REQ-024 WAIT with inst_data_ok=1, no cancel, flush=0: inst_o<=inst_rdata, inst_pc_o<=req_pc, inst_valid_o<=1, and the FSM goes to DONE; data is visible one cycle after data_ok.
REQ-025 DONE: inst_o, inst_pc_o and inst_valid_o SHALL hold while stall=1 and flush=0.
REQ-026 DONE with flush=1: inst_valid_o<=0 and the FSM goes to REQ; flush has priority over stall.
REQ-027 DONE with stall=0, flush=0: the instruction is consumed; inst_valid_o<=0 and the FSM goes to REQ.
REQ-028 pc_read_ready SHALL be 1 only in REQ-state handshake cycles, never in any other state or cycle.
REQ-029 inst_data_ok SHALL be ignored in IDLE, REQ and DONE.
REQ-030 inst_addr_ok SHALL be ignored outside REQ.
REQ-031 The minimum fetch rate SHALL be one instruction per 3 cycles with a zero-latency bus (REQ->WAIT->DONE).

Reset
REQ-032 rst=1 SHALL force, at the next edge regardless of state: state=IDLE, cancel=0, req_pc=0, inst_o=0, inst_pc_o=0, inst_valid_o=0.
REQ-033 During rst, inst_req, pc_read_ready and busy_o SHALL be 0.
REQ-034 Reset mid-transaction discards any outstanding request. The bus slave SHALL share the same rst, so no stale inst_data_ok is delivered afterwards.

Verification
REQ-035 Boot: rst 1->0, pc_i=0xbfc00000, addr_ok=1 in REQ, data_ok the next cycle with 0x3c08bfc0 -> pc_read_ready pulses once; the cycle after data_ok, inst_o=0x3c08bfc0, inst_pc_o=0xbfc00000, inst_valid_o=1.
REQ-036 Slow bus: addr_ok held low for 3 cycles -> inst_req stays 1, inst_addr tracks pc_i, pc_read_ready=0 until the addr_ok cycle.
REQ-037 Flush in WAIT: flush=1 two cycles before data_ok, pc_i=0xbfc00380 -> the returned data is dropped (inst_valid_o never 1); next handshake uses addr 0xbfc00380.
REQ-038 Flush coincident with data_ok -> data dropped, FSM in REQ the next cycle, cancel=0.
REQ-039 Stall in DONE for 4 cycles -> inst_o/inst_pc_o/inst_valid_o stable for 4 cycles, no inst_req; stall=0 -> valid drops and inst_req=1 the next cycle.
REQ-040 rst asserted in WAIT -> next cycle all outputs 0 and state IDLE; a fresh fetch follows after rst deasserts.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues one SRAM-like read per instruction,
// keeps at most one transaction outstanding, drops data returning after a
// flush, and presents the fetched instruction to IF/ID until it is consumed.
module inst_fetch_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic        stall,
   input  logic        flush,
   output logic        pc_read_ready,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   output logic        inst_valid_o,
   output logic        busy_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]  state;
   logic        cancel;
   logic [31:0] req_pc;
   logic        in_req;

   // Bus-side request signals; all forced low while reset is asserted.
   always_comb begin
      in_req        = (state == S_REQ) && !rst;
      inst_req      = in_req && (!stall || flush);
      inst_addr     = in_req ? pc_i : '0;
      pc_read_ready = inst_req && inst_addr_ok;
      busy_o        = !rst && ((state == S_REQ) || (state == S_WAIT));
   end

   // Fetch sequencing: address handshake, data return, hold until consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cancel       <= 1'b0;
         req_pc       <= '0;
         inst_o       <= '0;
         inst_pc_o    <= '0;
         inst_valid_o <= 1'b0;
      end else begin
         case (state)
            S_IDLE: state <= S_REQ;
            S_REQ: begin
               if (pc_read_ready) begin
                  req_pc <= pc_i;
                  state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (inst_data_ok) begin
                  if (cancel || flush) begin
                     cancel <= 1'b0;
                     state  <= S_REQ;
                  end else begin
                     inst_o       <= inst_rdata;
                     inst_pc_o    <= req_pc;
                     inst_valid_o <= 1'b1;
                     state        <= S_DONE;
                  end
               end else if (flush) begin
                  cancel <= 1'b1;
               end
            end
            S_DONE: begin
               if (flush || !stall) begin
                  inst_valid_o <= 1'b0;
                  state        <= S_REQ;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_inst_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst, stall, flush, inst_addr_ok, inst_data_ok;
   logic [31:0] pc_i, inst_rdata;
   logic        pc_read_ready, inst_req, inst_valid_o, busy_o;
   logic [31:0] inst_addr, inst_o, inst_pc_o;

   int n_vec = 0;
   int n_err = 0;

   // model: booted = past the post-reset idle cycle; outstanding = address
   // accepted, data not yet back; drop = data of outstanding read is stale;
   // have = an instruction is being presented downstream
   bit          m_booted, m_out, m_drop, m_have;
   logic [31:0] m_inst, m_pc, m_reqpc;

   inst_fetch_ctrl dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .stall(stall), .flush(flush),
      .pc_read_ready(pc_read_ready), .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
      .inst_valid_o(inst_valid_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_booted = 0; m_out = 0; m_drop = 0; m_have = 0;
      m_inst = '0; m_pc = '0; m_reqpc = '0;
   endtask

   // One cycle: apply inputs, check all outputs against the model, clock,
   // then advance the model with the same inputs.
   task automatic step(input bit r, input bit s, input bit f, input logic [31:0] p,
                       input bit a, input bit d, input logic [31:0] rd);
      bit requesting, e_req, e_prr;
      rst = r; stall = s; flush = f; pc_i = p;
      inst_addr_ok = a; inst_data_ok = d; inst_rdata = rd;
      #2;
      requesting = !r && m_booted && !m_out && !m_have;
      e_req = requesting && (!s || f);
      e_prr = e_req && a;
      chk("inst_req", {31'b0, inst_req}, {31'b0, e_req});
      chk("pc_read_ready", {31'b0, pc_read_ready}, {31'b0, e_prr});
      chk("inst_addr", inst_addr, requesting ? p : 32'h0);
      chk("busy_o", {31'b0, busy_o}, {31'b0, !r && m_booted && !m_have});
      chk("inst_valid_o", {31'b0, inst_valid_o}, {31'b0, m_have});
      chk("inst_o", inst_o, m_inst);
      chk("inst_pc_o", inst_pc_o, m_pc);
      @(posedge clk);
      if (r) model_reset();
      else if (!m_booted) m_booted = 1;
      else if (m_have) begin
         if (f || !s) m_have = 0;
      end else if (m_out) begin
         if (d) begin
            m_out = 0;
            if (m_drop || f) m_drop = 0;
            else begin m_have = 1; m_inst = rd; m_pc = m_reqpc; end
         end else if (f) m_drop = 1;
      end else if (e_prr) begin
         m_out = 1; m_reqpc = p;
      end
      #1;
   endtask

   initial begin
      rst = 1; stall = 0; flush = 0; pc_i = '0;
      inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
      @(posedge clk); #1;
      model_reset();

      // reset state, with bus noise that must be ignored
      step(1, 0, 0, 32'h1234, 1, 1, 32'hdead);
      step(1, 0, 1, 32'h5678, 1, 0, 32'h0);

      // boot fetch
      step(0, 0, 0, 32'hbfc00000, 1, 1, 32'h11111111);   // idle cycle
      step(0, 0, 0, 32'hbfc00000, 1, 0, 32'h0);          // handshake
      step(0, 1, 0, 32'hbfc00004, 0, 1, 32'h3c08bfc0);   // data_ok
      chk("boot_inst", inst_o, 32'h3c08bfc0);
      chk("boot_pc", inst_pc_o, 32'hbfc00000);
      chk("boot_valid", {31'b0, inst_valid_o}, 32'd1);

      // stall in DONE for 4 cycles, then release
      for (int unsigned i = 0; i < 4; i++)
         step(0, 1, 0, 32'hbfc00004, 1, 1, 32'hffffffff);
      chk("stall_hold_inst", inst_o, 32'h3c08bfc0);
      step(0, 0, 0, 32'hbfc00004, 1, 0, 32'h0);          // consumed
      chk("consume_valid", {31'b0, inst_valid_o}, 32'd0);

      // slow bus: addr_ok low for 3 cycles with moving pc
      step(0, 0, 0, 32'hbfc00004, 0, 1, 32'h0);
      step(0, 0, 0, 32'hbfc00008, 0, 0, 32'h0);
      step(0, 0, 0, 32'hbfc0000c, 0, 0, 32'h0);
      step(0, 0, 0, 32'hbfc00010, 1, 0, 32'h0);          // handshake
      // flush two cycles before data_ok
      step(0, 0, 1, 32'hbfc00380, 0, 0, 32'h0);
      step(0, 0, 0, 32'hbfc00380, 0, 0, 32'h0);
      step(0, 0, 0, 32'hbfc00380, 0, 1, 32'h22222222);   // dropped
      chk("flush_drop_valid", {31'b0, inst_valid_o}, 32'd0);
      step(0, 0, 0, 32'hbfc00380, 1, 0, 32'h0);          // handshake
      step(0, 0, 0, 32'hbfc00384, 0, 1, 32'h33333333);
      chk("after_flush_pc", inst_pc_o, 32'hbfc00380);

      // flush during DONE with stall, then flush coincident with data_ok
      step(0, 1, 1, 32'hbfc00400, 1, 0, 32'h0);
      step(0, 1, 1, 32'hbfc00400, 1, 0, 32'h0);          // flush overrides stall
      step(0, 0, 1, 32'hbfc00404, 0, 1, 32'h44444444);   // dropped
      step(0, 0, 0, 32'hbfc00408, 1, 0, 32'h0);
      step(0, 0, 0, 32'hbfc0040c, 0, 1, 32'h55555555);   // no stale cancel
      chk("coincident_inst", inst_o, 32'h55555555);

      // reset in WAIT, then a fresh fetch
      step(0, 0, 0, 32'hbfc00500, 1, 0, 32'h0);
      step(0, 0, 0, 32'hbfc00500, 1, 0, 32'h0);
      step(0, 0, 0, 32'hbfc00504, 0, 0, 32'h0);
      step(1, 0, 0, 32'hbfc00504, 0, 0, 32'h0);
      chk("rst_inst", inst_o, 32'h0);
      step(0, 0, 0, 32'hbfc00000, 1, 0, 32'h0);
      step(0, 0, 0, 32'hbfc00000, 1, 0, 32'h0);
      step(0, 0, 0, 32'hbfc00004, 0, 1, 32'h66666666);
      step(0, 0, 0, 32'hbfc00004, 0, 0, 32'h0);

      // randomized traffic
      for (int unsigned i = 0; i < 600; i++)
         step($urandom_range(63) == 0, $urandom_range(2) == 0, $urandom_range(7) == 0,
              $urandom, $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
